c64_bus_arbiter: RTL and testbench

Shares the single 64 KB system RAM between the 6502 core and the video chip (VIC).
- Time-multiplexes each CPU cycle into a VIC slot and a CPU slot.
- Supplies the CPU a clock enable.
- Implements the BA/AEC cycle-steal sequence so the VIC can take both slots during badline/sprite bursts.
- Sits between the `_6502` instance, the VIC fetch unit and the RAM array.

---
 rtl/c64_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_c64_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/c64_bus_arbiter.sv
// c64_bus_arbiter: shares the 64 KB system RAM between the 6502 core and the VIC.
// Each CPU cycle is two clk slots: a VIC slot (phase=0) and a CPU slot (phase=1).
// A level vic_req starts the BA/AEC steal: ba drops, the CPU is held on its
// next reads for BA_DELAY CPU slots (writes still complete), then aec drops and
// the VIC owns both slots until vic_req is released.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   cpu_ab/do/we        CPU address, write data, write strobe
//   cpu_di              registered read data to CPU
//   cpu_ce              CPU clock enable (combinational)
//   vic_req             level burst request from VIC
//   vic_ab, vic_bank    VIC fetch address and bank; RAM address {vic_bank, vic_ab}
//   vic_di, vic_valid   registered fetch data to VIC and its update pulse
//   ba, aec             registered bus-available / address-enable
//   ram_ab/do/we/di     RAM port (address mux, write data, write enable, read data)
module c64_bus_arbiter #(
    parameter int unsigned BA_DELAY = 3,
    parameter int unsigned VIC_AW   = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       cpu_ab,
    input  logic [7:0]        cpu_do,
    input  logic              cpu_we,
    output logic [7:0]        cpu_di,
    output logic              cpu_ce,
    input  logic              vic_req,
    input  logic [VIC_AW-1:0] vic_ab,
    input  logic [1:0]        vic_bank,
    output logic [7:0]        vic_di,
    output logic              vic_valid,
    output logic              ba,
    output logic              aec,
    output logic [15:0]       ram_ab,
    output logic [7:0]        ram_do,
    output logic              ram_we,
    input  logic [7:0]        ram_di
);

    localparam int unsigned AW    = 16;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        BA_WAIT = 2'd1,
        STOLEN  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               phase;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               ba_nxt, aec_nxt;
    logic               cpu_owns;
    logic               vic_slot;
    logic [AW-1:0]      vic_addr;

    assign vic_addr = AW'({vic_bank, vic_ab});

    // State register plus registered data/handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase     <= 1'b0;
            state     <= NORMAL;
            cnt       <= '0;
            ba        <= 1'b1;
            aec       <= 1'b1;
            cpu_di    <= '0;
            vic_di    <= '0;
            vic_valid <= 1'b0;
        end else begin
            phase     <= ~phase;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ba        <= ba_nxt;
            aec       <= aec_nxt;
            vic_valid <= vic_slot;
            if (vic_slot) begin
                vic_di <= ram_di;
            end
            if (cpu_owns) begin
                cpu_di <= ram_di;
            end
        end
    end

    // Next state: transitions only at VIC-slot edges; stall counter ticks on CPU slots
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (phase) begin
            if (state == BA_WAIT) begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else begin
            case (state)
                NORMAL: begin
                    if (vic_req) begin
                        state_nxt = BA_WAIT;
                        cnt_nxt   = '0;
                    end
                end
                BA_WAIT: begin
                    if (!vic_req) begin
                        state_nxt = NORMAL;
                    end else if (cnt == CNT_W'(BA_DELAY)) begin
                        state_nxt = STOLEN;
                    end
                end
                STOLEN: begin
                    if (!vic_req) begin
                        state_nxt = NORMAL;
                    end
                end
                default: state_nxt = NORMAL;
            endcase
        end
        // ba low whenever a steal is pending or active; aec low only while stolen
        ba_nxt  = (state_nxt == NORMAL);
        aec_nxt = (state_nxt != STOLEN);
    end

    // Outputs: RAM mux, write enable and CPU clock enable
    always_comb begin
        // CPU gets the slot in NORMAL, and in BA_WAIT only to finish a write
        cpu_owns = phase && ((state == NORMAL) || ((state == BA_WAIT) && cpu_we));
        vic_slot = !phase || (state == STOLEN);
        cpu_ce   = cpu_owns && !reset;
        ram_we   = cpu_owns && cpu_we && !reset;
        ram_ab   = (phase && (state != STOLEN)) ? cpu_ab : vic_addr;
        ram_do   = cpu_do;
    end

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Directed bench for c64_bus_arbiter: per-slot vector table plus hand sequences
// for reset-in-steal and bank addressing. RAM is modelled here.
module tb_c64_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic [7:0]  cpu_di;
    logic        cpu_ce;
    logic        vic_req;
    logic [13:0] vic_ab;
    logic [1:0]  vic_bank;
    logic [7:0]  vic_di;
    logic        vic_valid;
    logic        ba;
    logic        aec;
    logic [15:0] ram_ab;
    logic [7:0]  ram_do;
    logic        ram_we;
    logic [7:0]  ram_di;

    logic [7:0]  mem [0:65535];
    logic        pl_en;
    logic [15:0] pl_a;
    logic [7:0]  pl_d;

    int n_vec;
    int n_err;

    c64_bus_arbiter #(.BA_DELAY(3), .VIC_AW(14)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_ab    (cpu_ab),
        .cpu_do    (cpu_do),
        .cpu_we    (cpu_we),
        .cpu_di    (cpu_di),
        .cpu_ce    (cpu_ce),
        .vic_req   (vic_req),
        .vic_ab    (vic_ab),
        .vic_bank  (vic_bank),
        .vic_di    (vic_di),
        .vic_valid (vic_valid),
        .ba        (ba),
        .aec       (aec),
        .ram_ab    (ram_ab),
        .ram_do    (ram_do),
        .ram_we    (ram_we),
        .ram_di    (ram_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read, write on clk edge; preload port used during reset
    assign ram_di = mem[ram_ab];
    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (ram_we) mem[ram_ab] <= ram_do;
    end

    typedef struct {
        logic [15:0] ab;
        logic [7:0]  dout;
        logic        we;
        logic        req;
        logic [13:0] vab;
        logic        e_ce;
        logic        e_we;
        logic [15:0] e_ab;
        logic        e_ba;
        logic        e_aec;
        logic        e_vv;
        logic        c_cdi;
        logic [7:0]  e_cdi;
        logic        c_vdi;
        logic [7:0]  e_vdi;
    } vec_t;

    vec_t vt [28];

    function automatic vec_t mk(logic [15:0] ab, logic [7:0] dout, logic we, logic req,
                                logic [13:0] vab, logic ce, logic rwe, logic [15:0] rab,
                                logic eba, logic eaec, logic evv, logic ccdi, logic [7:0] ecdi,
                                logic cvdi, logic [7:0] evdi);
        vec_t v;
        v.ab = ab; v.dout = dout; v.we = we; v.req = req; v.vab = vab;
        v.e_ce = ce; v.e_we = rwe; v.e_ab = rab; v.e_ba = eba; v.e_aec = eaec;
        v.e_vv = evv; v.c_cdi = ccdi; v.e_cdi = ecdi; v.c_vdi = cvdi; v.e_vdi = evdi;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        pl_en = 1'b0; pl_a = '0; pl_d = '0;
        cpu_ab = 16'h0324; cpu_do = 8'h00; cpu_we = 1'b1;
        vic_req = 1'b1; vic_ab = '0; vic_bank = 2'b00;
        reset = 1'b0;
        #1 reset = 1'b1;

        // Slot-by-slot table (starts on the VIC slot right after reset release)
        //        ab       do    we   req  vab      ce   we   ram_ab   ba   aec  vv   c  cdi    c  vdi
        vt[0]  = mk(16'h0324, 8'h77, 1, 0, 14'h0400, 0, 0, 16'h0400, 1, 1, 1, 0, 8'h00, 1, 8'h5A);
        vt[1]  = mk(16'h0324, 8'h77, 1, 0, 14'h0400, 1, 1, 16'h0324, 1, 1, 0, 0, 8'h00, 0, 8'h00);
        vt[2]  = mk(16'h0030, 8'h00, 0, 0, 14'h0324, 0, 0, 16'h0324, 1, 1, 1, 0, 8'h00, 1, 8'h77);
        vt[3]  = mk(16'h0030, 8'h00, 0, 0, 14'h0324, 1, 0, 16'h0030, 1, 1, 0, 1, 8'h47, 0, 8'h00);
        // steal with reads: three stalled CPU slots, then aec falls
        vt[4]  = mk(16'h0030, 8'h00, 0, 1, 14'h0400, 0, 0, 16'h0400, 0, 1, 1, 1, 8'h47, 1, 8'h5A);
        vt[5]  = mk(16'h0030, 8'h00, 0, 1, 14'h0400, 0, 0, 16'h0030, 0, 1, 0, 1, 8'h47, 0, 8'h00);
        vt[6]  = mk(16'h0030, 8'h00, 0, 1, 14'h0324, 0, 0, 16'h0324, 0, 1, 1, 0, 8'h00, 1, 8'h77);
        vt[7]  = mk(16'h0030, 8'h00, 0, 1, 14'h0324, 0, 0, 16'h0030, 0, 1, 0, 1, 8'h47, 0, 8'h00);
        vt[8]  = mk(16'h0030, 8'h00, 0, 1, 14'h0400, 0, 0, 16'h0400, 0, 1, 1, 0, 8'h00, 1, 8'h5A);
        vt[9]  = mk(16'h0030, 8'h00, 0, 1, 14'h0400, 0, 0, 16'h0030, 0, 1, 0, 1, 8'h47, 0, 8'h00);
        vt[10] = mk(16'h0030, 8'h00, 0, 1, 14'h0324, 0, 0, 16'h0324, 0, 0, 1, 0, 8'h00, 1, 8'h77);
        // stolen CPU slot: VIC fetches, a CPU write must not reach RAM
        vt[11] = mk(16'h0030, 8'hFF, 1, 1, 14'h0400, 0, 0, 16'h0400, 0, 0, 1, 1, 8'h47, 1, 8'h5A);
        vt[12] = mk(16'h0030, 8'h00, 0, 0, 14'h0324, 0, 0, 16'h0324, 1, 1, 1, 0, 8'h00, 1, 8'h77);
        vt[13] = mk(16'h0030, 8'h00, 0, 0, 14'h0324, 1, 0, 16'h0030, 1, 1, 0, 1, 8'h47, 0, 8'h00);
        // steal with writes: all three complete during BA_WAIT
        vt[14] = mk(16'h0010, 8'h01, 1, 1, 14'h0400, 0, 0, 16'h0400, 0, 1, 1, 0, 8'h00, 1, 8'h5A);
        vt[15] = mk(16'h0010, 8'h01, 1, 1, 14'h0400, 1, 1, 16'h0010, 0, 1, 0, 0, 8'h00, 0, 8'h00);
        vt[16] = mk(16'h0011, 8'h02, 1, 1, 14'h0010, 0, 0, 16'h0010, 0, 1, 1, 0, 8'h00, 1, 8'h01);
        vt[17] = mk(16'h0011, 8'h02, 1, 1, 14'h0010, 1, 1, 16'h0011, 0, 1, 0, 0, 8'h00, 0, 8'h00);
        vt[18] = mk(16'h0012, 8'h03, 1, 1, 14'h0011, 0, 0, 16'h0011, 0, 1, 1, 0, 8'h00, 1, 8'h02);
        vt[19] = mk(16'h0012, 8'h03, 1, 1, 14'h0011, 1, 1, 16'h0012, 0, 1, 0, 0, 8'h00, 0, 8'h00);
        vt[20] = mk(16'h0030, 8'h00, 0, 1, 14'h0012, 0, 0, 16'h0012, 0, 0, 1, 0, 8'h00, 1, 8'h03);
        vt[21] = mk(16'h0030, 8'h00, 0, 1, 14'h0012, 0, 0, 16'h0012, 0, 0, 1, 0, 8'h00, 1, 8'h03);
        vt[22] = mk(16'h0030, 8'h00, 0, 0, 14'h0400, 0, 0, 16'h0400, 1, 1, 1, 0, 8'h00, 1, 8'h5A);
        vt[23] = mk(16'h0030, 8'h00, 0, 0, 14'h0400, 1, 0, 16'h0030, 1, 1, 0, 1, 8'h47, 0, 8'h00);
        // abort: request held for one CPU cycle only
        vt[24] = mk(16'h0011, 8'h00, 0, 1, 14'h0400, 0, 0, 16'h0400, 0, 1, 1, 1, 8'h47, 1, 8'h5A);
        vt[25] = mk(16'h0011, 8'h00, 0, 1, 14'h0400, 0, 0, 16'h0011, 0, 1, 0, 1, 8'h47, 0, 8'h00);
        vt[26] = mk(16'h0011, 8'h00, 0, 0, 14'h0400, 0, 0, 16'h0400, 1, 1, 1, 1, 8'h47, 1, 8'h5A);
        vt[27] = mk(16'h0011, 8'h00, 0, 0, 14'h0400, 1, 0, 16'h0011, 1, 1, 0, 1, 8'h02, 0, 8'h00);

        // RAM preload while the arbiter is held in reset
        preload(16'h0400, 8'h5A);
        preload(16'h0030, 8'h47);
        preload(16'h0324, 8'h00);
        preload(16'h0010, 8'h00);
        preload(16'h0011, 8'h00);
        preload(16'h0012, 8'h00);
        preload(16'h0020, 8'h00);

        // Reset values, with cpu_we and vic_req both high
        chk("rst_cpu_ce", 16'(cpu_ce), 16'h0);
        chk("rst_ram_we", 16'(ram_we), 16'h0);
        chk("rst_ba", 16'(ba), 16'h1);
        chk("rst_aec", 16'(aec), 16'h1);
        chk("rst_vic_valid", 16'(vic_valid), 16'h0);
        chk("rst_cpu_di", 16'(cpu_di), 16'h0);
        chk("rst_vic_di", 16'(vic_di), 16'h0);

        reset = 1'b0;
        for (int i = 0; i < 28; i++) begin
            cpu_ab = vt[i].ab; cpu_do = vt[i].dout; cpu_we = vt[i].we;
            vic_req = vt[i].req; vic_ab = vt[i].vab;
            #1;
            chk($sformatf("v%0d_cpu_ce", i), 16'(cpu_ce), 16'(vt[i].e_ce));
            chk($sformatf("v%0d_ram_we", i), 16'(ram_we), 16'(vt[i].e_we));
            chk($sformatf("v%0d_ram_ab", i), ram_ab, vt[i].e_ab);
            @(posedge clk); #1;
            chk($sformatf("v%0d_ba", i), 16'(ba), 16'(vt[i].e_ba));
            chk($sformatf("v%0d_aec", i), 16'(aec), 16'(vt[i].e_aec));
            chk($sformatf("v%0d_vic_valid", i), 16'(vic_valid), 16'(vt[i].e_vv));
            if (vt[i].c_cdi) chk($sformatf("v%0d_cpu_di", i), 16'(cpu_di), 16'(vt[i].e_cdi));
            if (vt[i].c_vdi) chk($sformatf("v%0d_vic_di", i), 16'(vic_di), 16'(vt[i].e_vdi));
        end

        // RAM contents after the table
        chk("mem_0324", 16'(mem[16'h0324]), 16'h0077);
        chk("mem_0010", 16'(mem[16'h0010]), 16'h0001);
        chk("mem_0011", 16'(mem[16'h0011]), 16'h0002);
        chk("mem_0012", 16'(mem[16'h0012]), 16'h0003);
        chk("mem_0030", 16'(mem[16'h0030]), 16'h0047);

        // Bank select forms the upper address bits in a VIC slot
        vic_bank = 2'b10; vic_ab = 14'h0123; cpu_we = 1'b0;
        #1;
        chk("bank_ram_ab", ram_ab, 16'h8123);
        @(posedge clk); #1;
        @(posedge clk); #1;
        vic_bank = 2'b00;

        // Reset while stolen, CPU attempting a write
        begin
            bit reached;
            reached = 1'b0;
            vic_req = 1'b1; vic_ab = 14'h0400;
            for (int k = 0; k < 20 && !reached; k++) begin
                @(posedge clk); #1;
                if (!aec) reached = 1'b1;
            end
            chk("steal_reached", 16'(reached), 16'h1);
        end
        cpu_ab = 16'h0020; cpu_do = 8'hAA; cpu_we = 1'b1;
        #1;
        chk("stolen_ram_we", 16'(ram_we), 16'h0);
        reset = 1'b1;
        #1;
        chk("rs_ba", 16'(ba), 16'h1);
        chk("rs_aec", 16'(aec), 16'h1);
        chk("rs_ram_we", 16'(ram_we), 16'h0);
        chk("rs_cpu_ce", 16'(cpu_ce), 16'h0);
        chk("rs_vic_valid", 16'(vic_valid), 16'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rs_mem_0020", 16'(mem[16'h0020]), 16'h0000);

        // vic_req still high: takes effect at the first VIC-slot edge after release
        cpu_we = 1'b0;
        reset = 1'b0;
        #1;
        chk("post_rst_ba_before_edge", 16'(ba), 16'h1);
        @(posedge clk); #1;
        chk("post_rst_ba", 16'(ba), 16'h0);
        chk("post_rst_aec", 16'(aec), 16'h1);
        vic_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("post_rst_ba_release", 16'(ba), 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
